// File: rtl/data_bus_pkg.sv
// Shared types for the CPU data/instruction-side bus routers.
// Latency: n/a (types and a constant function only).
// Backpressure: n/a.
package data_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Access size codes carried through to the slaves untouched.
    typedef enum logic [2:0] {
        SIZE_BYTE   = 3'd0,
        SIZE_HALF   = 3'd1,
        SIZE_WORD   = 3'd2,
        SIZE_BYTE_U = 3'd4,
        SIZE_HALF_U = 3'd5
    } size_t;

    // Width of a region index; never below one bit so single-region builds still have a port.
    function automatic int region_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/data_bus_router_region_select.sv
// Decodes the region-select bit-field of a byte address.
// Latency: combinational.
// Backpressure: none.
// Ports: address in; region = address[SEL_HI:SEL_LO] (truncated to RW bits),
//        valid = field < NUM_REGIONS, address_clr = address with the field zeroed.
module region_select
    import data_bus_pkg::*;
#(
    parameter int NUM_REGIONS = 2,
    parameter int SEL_HI      = 31,
    parameter int SEL_LO      = 31,
    parameter int RW          = region_w(NUM_REGIONS)
) (
    input  logic [31:0]   address,
    output logic [RW-1:0] region,
    output logic          valid,
    output logic [31:0]   address_clr
);

    localparam int          FW         = SEL_HI - SEL_LO + 1;
    localparam logic [31:0] FIELD_MASK = 32'((64'd1 << FW) - 64'd1);
    localparam logic [31:0] CLR_MASK   = ~(FIELD_MASK << SEL_LO);

    logic [31:0] field;

    assign field       = (address >> SEL_LO) & FIELD_MASK;
    // The full field is compared, so an out-of-range value is caught even though
    // only RW bits are forwarded as the index.
    assign region      = field[RW-1:0];
    assign valid       = field < 32'(NUM_REGIONS);
    assign address_clr = address & CLR_MASK;

endmodule

// File: rtl/data_bus_router.sv
// Routes CPU data-port transactions to NUM_REGIONS slaves by an address bit-field.
// Latency: request -> data_ready >= 2 cycles (1 cycle for a decode error).
// Backpressure: one transaction outstanding; slave enable held until slv_ready.
// Ports: clk/rst (sync, active high); CPU side data_*; slave side slv_* with
//        one-hot read/write strobes and flattened read data (region k at [32k+31:32k]).
// Optional macro ROUTER_TIMEOUT_EN: error response after TIMEOUT_CYCLES of slave wait.
module data_bus_router
    import data_bus_pkg::*;
#(
    parameter int NUM_REGIONS    = 2,
    parameter int SEL_HI         = 31,
    parameter int SEL_LO         = 31,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               data_address,
    input  logic                      data_read_en,
    input  logic                      data_write_en,
    input  logic [31:0]               data_write_value,
    input  logic [2:0]                data_size,
    output logic [31:0]               data_read_value,
    output logic                      data_ready,
    output logic                      data_error,
    output logic [31:0]               slv_address,
    output logic [31:0]               slv_write_value,
    output logic [2:0]                slv_data_size,
    output logic [NUM_REGIONS-1:0]    slv_read_en,
    output logic [NUM_REGIONS-1:0]    slv_write_en,
    input  logic [NUM_REGIONS*32-1:0] slv_read_value,
    input  logic [NUM_REGIONS-1:0]    slv_ready
);

    localparam int RW = region_w(NUM_REGIONS);

    if (NUM_REGIONS < 1 || NUM_REGIONS > 8 || SEL_HI < SEL_LO || SEL_HI - SEL_LO > 2
        || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_params
        $error("data_bus_router: parameter out of range");
    end

    state_t        state, state_nxt;
    logic [RW-1:0] dec_region, lat_region;
    logic          dec_valid;
    logic [31:0]   dec_address;
    logic          req, dec_err;
    logic          lat_read, lat_write;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          sel_ready;
    logic [31:0]   sel_rdata;
    logic          timeout_hit;

    region_select #(
        .NUM_REGIONS (NUM_REGIONS),
        .SEL_HI      (SEL_HI),
        .SEL_LO      (SEL_LO),
        .RW          (RW)
    ) u_region_select (
        .address     (data_address),
        .region      (dec_region),
        .valid       (dec_valid),
        .address_clr (dec_address)
    );

    assign req     = data_read_en | data_write_en;
    assign dec_err = !dec_valid || (data_read_en && data_write_en);

`ifdef ROUTER_TIMEOUT_EN
    logic [7:0] tcount;
    assign timeout_hit = (tcount == 8'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    // Strobes come straight from the latched direction flags, which are only
    // set while in ACCESS, so they drop on the same edge that leaves ACCESS.
    always_comb begin
        slv_read_en  = '0;
        slv_write_en = '0;
        sel_ready    = 1'b0;
        sel_rdata    = '0;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            if (lat_region == RW'(k)) begin
                slv_read_en[k]  = lat_read;
                slv_write_en[k] = lat_write;
                sel_ready       = slv_ready[k];
                sel_rdata       = slv_read_value[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = dec_err ? RESP : ACCESS;
            ACCESS:  if (sel_ready || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slv_address     <= '0;
            slv_write_value <= '0;
            slv_data_size   <= '0;
            lat_region      <= '0;
            lat_read        <= 1'b0;
            lat_write       <= 1'b0;
            rdata_q         <= '0;
            err_q           <= 1'b0;
`ifdef ROUTER_TIMEOUT_EN
            tcount          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        slv_address     <= dec_address;
                        slv_write_value <= data_write_value;
                        slv_data_size   <= data_size;
                        lat_region      <= dec_region;
                        lat_read        <= data_read_en && !dec_err;
                        lat_write       <= data_write_en && !dec_err;
                        err_q           <= dec_err;
                        rdata_q         <= '0;
`ifdef ROUTER_TIMEOUT_EN
                        tcount          <= '0;
`endif
                    end
                end
                ACCESS: begin
                    // Ready in the timeout cycle still completes cleanly.
                    if (sel_ready) begin
                        rdata_q   <= lat_read ? sel_rdata : 32'd0;
                        err_q     <= 1'b0;
                        lat_read  <= 1'b0;
                        lat_write <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        lat_read  <= 1'b0;
                        lat_write <= 1'b0;
                    end
`ifdef ROUTER_TIMEOUT_EN
                    else begin
                        tcount <= tcount + 8'd1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign data_ready      = (state == RESP);
    assign data_error      = data_ready & err_q;
    assign data_read_value = data_ready ? rdata_q : 32'd0;

endmodule

// File: tb/tb_data_bus_router.sv
module tb_data_bus_router;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] data_address, data_write_value;
    logic [2:0]  data_size;
    logic        rd_a, wr_a, rd_b, wr_b;

    // Instance A: default 2-region split on bit 31.
    logic [31:0] rv_a, sa_a, sw_a;
    logic        rdy_a, err_a;
    logic [2:0]  ss_a;
    logic [1:0]  sre_a, swe_a, srdy_a;
    logic [63:0] srv_a;

    // Instance B: 3 regions on bits 31:30.
    logic [31:0] rv_b, sa_b, sw_b;
    logic        rdy_b, err_b;
    logic [2:0]  ss_b;
    logic [2:0]  sre_b, swe_b, srdy_b;
    logic [95:0] srv_b;

    data_bus_router #(.NUM_REGIONS(2), .SEL_HI(31), .SEL_LO(31), .TIMEOUT_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .data_address(data_address), .data_read_en(rd_a),
        .data_write_en(wr_a), .data_write_value(data_write_value), .data_size(data_size),
        .data_read_value(rv_a), .data_ready(rdy_a), .data_error(err_a),
        .slv_address(sa_a), .slv_write_value(sw_a), .slv_data_size(ss_a),
        .slv_read_en(sre_a), .slv_write_en(swe_a), .slv_read_value(srv_a), .slv_ready(srdy_a)
    );

    data_bus_router #(.NUM_REGIONS(3), .SEL_HI(31), .SEL_LO(30), .TIMEOUT_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .data_address(data_address), .data_read_en(rd_b),
        .data_write_en(wr_b), .data_write_value(data_write_value), .data_size(data_size),
        .data_read_value(rv_b), .data_ready(rdy_b), .data_error(err_b),
        .slv_address(sa_b), .slv_write_value(sw_b), .slv_data_size(ss_b),
        .slv_read_en(sre_b), .slv_write_en(swe_b), .slv_read_value(srv_b), .slv_ready(srdy_b)
    );

    // Slave model A: ready after sdelay enabled cycles (0 = never); unselected
    // slaves drive 'noise' on their ready line.
    int          sdelay = 1;
    logic        noise  = 1'b0;
    logic [31:0] rd0 = '0, rd1 = '0;
    int          scnt[2];
    assign srv_a = {rd1, rd0};
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (sre_a[k] | swe_a[k]) begin
                scnt[k]   = scnt[k] + 1;
                srdy_a[k] = (sdelay != 0) && (scnt[k] == sdelay);
            end else begin
                scnt[k]   = 0;
                srdy_a[k] = noise;
            end
        end
    end

    // Slave model B: immediate ready.
    assign srdy_b = sre_b | swe_b;
    assign srv_b  = {32'h2222_2222, 32'h1111_1111, 32'h0BAD_0000};

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;
    resp_t sb[$];
    resp_t exp_r;
    int    checks = 0;
    int    errors = 0;
    int    cyc;

    task automatic push_exp(input logic [31:0] d, input logic e);
        resp_t r;
        r.data = d;
        r.err  = e;
        sb.push_back(r);
    endtask

    // Request presented for one cycle (cycle 0); returns at the negedge of cycle 1.
    task automatic issue(input bit which, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] size);
        @(negedge clk);
        data_address     = addr;
        data_write_value = wdata;
        data_size        = size;
        if (which) begin rd_b = rd; wr_b = wr; end
        else       begin rd_a = rd; wr_a = wr; end
        @(negedge clk);
        rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
    endtask

    // Cycle index (relative to the request cycle) of data_ready, or -1 on timeout.
    task automatic wait_done(input bit which, output int c);
        c = 1;
        while (c <= 40 && !(which ? rdy_b : rdy_a)) begin
            @(negedge clk);
            c++;
        end
        if (c > 40) c = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rd_a = 0; wr_a = 0; rd_b = 0; wr_b = 0;
        data_address = '0; data_write_value = '0; data_size = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rv_a, rdy_a, err_a, sa_a, sw_a, ss_a, sre_a, swe_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: rdy=%b err=%b rv=%h addr=%h wv=%h sz=%h ren=%b wen=%b, want all 0",
                     rdy_a, err_a, rv_a, sa_a, sw_a, ss_a, sre_a, swe_a);
        end
        checks++;
        if ({rv_b, rdy_b, err_b, sa_b, sw_b, ss_b, sre_b, swe_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: rdy=%b err=%b rv=%h addr=%h ren=%b wen=%b, want all 0",
                     rdy_b, err_b, rv_b, sa_b, sre_b, swe_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_read();
        sdelay = 1; rd0 = 32'hDEAD_BEEF;
        push_exp(32'hDEAD_BEEF, 1'b0);
        issue(0, 1, 0, 32'h0000_0010, 32'h0, 3'd2);
        checks++;
        if (sre_a !== 2'b01 || swe_a !== 2'b00) begin
            errors++; $display("FAIL read_strobe: ren=%b wen=%b want 01/00", sre_a, swe_a);
        end
        checks++;
        if (sa_a !== 32'h10) begin
            errors++; $display("FAIL read_addr: got %h want 00000010", sa_a);
        end
        wait_done(0, cyc);
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL read_latency: got %0d want 2", cyc); end
        exp_r = sb.pop_front();
        checks++;
        if (rv_a !== exp_r.data || err_a !== exp_r.err) begin
            errors++; $display("FAIL read_resp: got %h/%b want %h/%b", rv_a, err_a, exp_r.data, exp_r.err);
        end
    endtask

    task automatic test_write();
        sdelay = 3; noise = 1'b1; rd1 = 32'hAAAA_5555;
        push_exp(32'h0, 1'b0);
        issue(0, 0, 1, 32'h8000_0004, 32'h1234_5678, 3'd1);
        checks++;
        if (swe_a !== 2'b10 || sre_a !== 2'b00) begin
            errors++; $display("FAIL write_strobe: wen=%b ren=%b want 10/00", swe_a, sre_a);
        end
        checks++;
        if (sa_a !== 32'h4) begin errors++; $display("FAIL write_addr: got %h want 00000004", sa_a); end
        checks++;
        if (sw_a !== 32'h1234_5678 || ss_a !== 3'd1) begin
            errors++; $display("FAIL write_data: got %h sz %0d want 12345678 sz 1", sw_a, ss_a);
        end
        checks++;
        if (rv_a !== 32'h0) begin errors++; $display("FAIL idle_rdata: got %h want 0", rv_a); end
        wait_done(0, cyc);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL write_latency: got %0d want 4", cyc); end
        exp_r = sb.pop_front();
        checks++;
        if (rv_a !== exp_r.data || err_a !== exp_r.err) begin
            errors++; $display("FAIL write_resp: got %h/%b want %h/%b", rv_a, err_a, exp_r.data, exp_r.err);
        end
        noise = 1'b0;
    endtask

    task automatic test_decode_error();
        push_exp(32'h0, 1'b1);
        issue(1, 1, 0, 32'hC000_0000, 32'h0, 3'd2);
        checks++;
        if (sre_b !== 3'b000 || swe_b !== 3'b000) begin
            errors++; $display("FAIL decode_strobe: ren=%b wen=%b want 000/000", sre_b, swe_b);
        end
        wait_done(1, cyc);
        checks++;
        if (cyc !== 1) begin errors++; $display("FAIL decode_latency: got %0d want 1", cyc); end
        exp_r = sb.pop_front();
        checks++;
        if (rv_b !== exp_r.data || err_b !== exp_r.err) begin
            errors++; $display("FAIL decode_resp: got %h/%b want %h/%b", rv_b, err_b, exp_r.data, exp_r.err);
        end
        push_exp(32'h2222_2222, 1'b0);
        issue(1, 1, 0, 32'h8000_0008, 32'h0, 3'd2);
        checks++;
        if (sre_b !== 3'b100 || sa_b !== 32'h8) begin
            errors++; $display("FAIL region2_strobe: ren=%b addr=%h want 100/00000008", sre_b, sa_b);
        end
        wait_done(1, cyc);
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL region2_latency: got %0d want 2", cyc); end
        exp_r = sb.pop_front();
        checks++;
        if (rv_b !== exp_r.data || err_b !== exp_r.err) begin
            errors++; $display("FAIL region2_resp: got %h/%b want %h/%b", rv_b, err_b, exp_r.data, exp_r.err);
        end
    endtask

    task automatic test_back_to_back();
        push_exp(32'h0, 1'b1);
        issue(0, 1, 1, 32'h0000_0010, 32'h0, 3'd2);
        checks++;
        if (sre_a !== 2'b00 || swe_a !== 2'b00) begin
            errors++; $display("FAIL both_strobe: ren=%b wen=%b want 00/00", sre_a, swe_a);
        end
        wait_done(0, cyc);
        checks++;
        if (cyc !== 1) begin errors++; $display("FAIL both_latency: got %0d want 1", cyc); end
        exp_r = sb.pop_front();
        checks++;
        if (rv_a !== exp_r.data || err_a !== exp_r.err) begin
            errors++; $display("FAIL both_resp: got %h/%b want %h/%b", rv_a, err_a, exp_r.data, exp_r.err);
        end
        // Next request lands in the IDLE cycle directly after RESP.
        sdelay = 1; rd0 = 32'h5A5A_A5A5;
        push_exp(32'h5A5A_A5A5, 1'b0);
        issue(0, 1, 0, 32'h0000_0020, 32'h0, 3'd2);
        wait_done(0, cyc);
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL b2b_latency: got %0d want 2", cyc); end
        exp_r = sb.pop_front();
        checks++;
        if (rv_a !== exp_r.data || err_a !== exp_r.err) begin
            errors++; $display("FAIL b2b_resp: got %h/%b want %h/%b", rv_a, err_a, exp_r.data, exp_r.err);
        end
    endtask

`ifdef ROUTER_TIMEOUT_EN
    task automatic test_timeout();
        sdelay = 0;
        push_exp(32'h0, 1'b1);
        issue(0, 1, 0, 32'h0000_0040, 32'h0, 3'd2);
        wait_done(0, cyc);
        checks++;
        if (cyc !== 6) begin errors++; $display("FAIL timeout_latency: got %0d want 6", cyc); end
        checks++;
        if (sre_a !== 2'b00) begin errors++; $display("FAIL timeout_strobe: ren=%b want 00", sre_a); end
        exp_r = sb.pop_front();
        checks++;
        if (rv_a !== exp_r.data || err_a !== exp_r.err) begin
            errors++; $display("FAIL timeout_resp: got %h/%b want %h/%b", rv_a, err_a, exp_r.data, exp_r.err);
        end
        sdelay = 5; rd0 = 32'h7777_0001;
        push_exp(32'h7777_0001, 1'b0);
        issue(0, 1, 0, 32'h0000_0044, 32'h0, 3'd2);
        wait_done(0, cyc);
        checks++;
        if (cyc !== 6) begin errors++; $display("FAIL edge_latency: got %0d want 6", cyc); end
        exp_r = sb.pop_front();
        checks++;
        if (rv_a !== exp_r.data || err_a !== exp_r.err) begin
            errors++; $display("FAIL edge_resp: got %h/%b want %h/%b", rv_a, err_a, exp_r.data, exp_r.err);
        end
    endtask
`endif

    task automatic test_reset_abort();
        bit seen;
        sdelay = 0;
        issue(0, 1, 0, 32'h0000_0030, 32'h0, 3'd2);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (sre_a !== 2'b00 || swe_a !== 2'b00 || rdy_a !== 1'b0) begin
            errors++; $display("FAIL abort_strobe: ren=%b wen=%b rdy=%b want 00/00/0", sre_a, swe_a, rdy_a);
        end
        rst  = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rdy_a) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_ready: saw data_ready=1 want none"); end
        sdelay = 2; rd0 = 32'h0F0F_0F0F;
        push_exp(32'h0F0F_0F0F, 1'b0);
        issue(0, 1, 0, 32'h0000_0014, 32'h0, 3'd2);
        wait_done(0, cyc);
        checks++;
        if (cyc !== 3) begin errors++; $display("FAIL post_abort_latency: got %0d want 3", cyc); end
        exp_r = sb.pop_front();
        checks++;
        if (rv_a !== exp_r.data || err_a !== exp_r.err) begin
            errors++; $display("FAIL post_abort_resp: got %h/%b want %h/%b", rv_a, err_a, exp_r.data, exp_r.err);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_decode_error();
        test_back_to_back();
`ifdef ROUTER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_abort();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/data_bus_router.md
Name: data_bus_router

Overview:
- Parametrised successor to the single-bit memory/IO split.
- Routes CPU data-port transactions to NUM_REGIONS slave regions, selected by a configurable address bit-field.
- Registered, one transaction outstanding: a request/ready handshake per slave, a decode-error path, and a returned read-data mux.
- Sits between the CPU data port and the memory, IO and peripheral blocks.

Parameters:
- NUM_REGIONS, 2, number of slave regions (1..8).
- SEL_HI, 31, MSB of the region-select field in the address.
- SEL_LO, 31, LSB of the region-select field; SEL_HI-SEL_LO+1 <= 3.
- TIMEOUT_CYCLES, 15, maximum slave wait before an error response (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- data_address  in  32  CPU byte address.
- data_read_en  in  1  read request; single-cycle pulse.
- data_write_en  in  1  write request; single-cycle pulse.
- data_write_value  in  32  write data.
- data_size  in  3  access size code, passed through unchanged.
- data_read_value  out  32  read data; valid while data_ready=1.
- data_ready  out  1  one-cycle completion pulse.
- data_error  out  1  with data_ready: decode error or timeout.
- slv_address  out  32  latched address with the select field cleared to 0.
- slv_write_value  out  32  latched write data.
- slv_data_size  out  3  latched size.
- slv_read_en  out  NUM_REGIONS  one-hot read strobe, held until that slave's ready.
- slv_write_en  out  NUM_REGIONS  one-hot write strobe, held until that slave's ready.
- slv_read_value  in  NUM_REGIONS*32  flattened slave read data; region k occupies bits [32k+31:32k].
- slv_ready  in  NUM_REGIONS  slave completion; read data valid in the same cycle.

Behaviour:
- Reset values:
  - state=IDLE.
  - All outputs 0, including slv_* enables and latched registers.
  - Timeout counter 0.
- Reset mid-transaction aborts it. No data_ready is issued and the slave enables drop on the next edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Sampled on any cycle with data_read_en|data_write_en.
  - Latch address, value, size and direction.
  - Compute region = data_address[SEL_HI:SEL_LO].
  - Decode error if region >= NUM_REGIONS, or if both enables are asserted. In that case go to RESP with error=1 and assert no slave enable.
  - Otherwise go to ACCESS with slv_read_en[region] or slv_write_en[region] set.
- ACCESS:
  - Enable held constant.
  - On slv_ready[region]=1: capture slv_read_value for that region (reads; writes capture 0), drop the enable, go to RESP.
  - slv_ready bits of non-selected regions are ignored.
- RESP:
  - data_ready=1 for exactly one cycle, data_error as determined, data_read_value = captured data (0 on error).
  - Return to IDLE.
- Latency:
  - Request in cycle 0; slave ready in cycle 1 at earliest; data_ready in cycle 2 at earliest.
  - Decode error: data_ready in cycle 1.
- CPU requests outside IDLE are ignored. The requester must not issue a new request before data_ready.
- A new request is accepted in the IDLE cycle that directly follows RESP (back-to-back).
- slv_read_value is captured only in ACCESS. data_read_value holds its last value after RESP is not required; it is driven 0 when data_ready=0.

Optional Feature:
- Macro: ROUTER_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ready.
  - When it reaches TIMEOUT_CYCLES, drop the enable and go to RESP with data_error=1.
  - Ready arriving in that same cycle wins; no error.
- Undefined: ACCESS waits indefinitely and the counter logic is absent.

Decomposition:
- Package data_bus_pkg:
  - state encoding (IDLE=0, ACCESS=1, RESP=2);
  - size codes (BYTE=0, HALF=1, WORD=2, plus unsigned variants);
  - region index width function.
- One sub-module, region_select: combinational.
  - Inputs: address, parameters.
  - Outputs: region index, valid flag, and address with the select field cleared.
  - Reused by the future instruction-side router.

Test Plan:
- Defaults. Read 0x0000_0010, slave0 ready 1 cycle later with 0xDEAD_BEEF -> slv_read_en=2'b01, slv_address=0x10, data_ready at cycle 2, value 0xDEAD_BEEF, error 0.
- Defaults. Write 0x8000_0004 value 0x1234_5678, slave1 ready after 3 cycles -> slv_write_en=2'b10, slv_address=0x4, slv_write_value=0x1234_5678, data_ready cycle 4, error 0.
- NUM_REGIONS=3, SEL_HI=31, SEL_LO=30. Read 0xC000_0000 -> no slave enable; data_ready+data_error at cycle 1, value 0.
- Read and write asserted together -> decode error response and no slave enable. Back-to-back read immediately after RESP is accepted.
- ROUTER_TIMEOUT_EN, TIMEOUT_CYCLES=4. Slave never ready -> enable drops and data_error=1 with data_ready. Rerun with ready exactly at count 4 -> no error.
- rst asserted during ACCESS -> all slv enables 0 next cycle, no data_ready. A subsequent read completes normally.
